// File: rtl/user_mux_pkg.sv
// Shared definitions for the two-tenant AXI-Stream packet merger:
// FSM state encodings and the position of the source tag inside tuser.
package user_mux_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PASS_0 = 2'd1;
    localparam logic [1:0] ST_PASS_1 = 2'd2;

    localparam int USER_ID_LSB   = 32;
    localparam int USER_ID_WIDTH = 8;

    function automatic logic [1:0] pass_state(input logic port);
        return port ? ST_PASS_1 : ST_PASS_0;
    endfunction

endpackage

// File: rtl/user_mux_if.sv
// One AXI-Stream link (data, keep, user, last, valid/ready) with master and slave views.
interface user_mux_if #(
    parameter int DATA_WIDTH  = 256,
    parameter int TUSER_WIDTH = 128
) ();

    // A beat transfers on a rising edge where tvalid && tready; while tvalid is
    // high and tready low the source holds the beat stable and keeps tvalid high.
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic [TUSER_WIDTH-1:0]  tuser;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);

endinterface

// File: rtl/user_mux_rr_arbiter2.sv
// Two-requestor round-robin pick; last_grant records the port whose packet finished last.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       update_id,
    output logic       grant_id
);

    logic last_grant;

    // Resetting to 1 lets port 0 win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (update) begin
            last_grant <= update_id;
        end
    end

    always_comb begin
        grant_id = 1'b0;
        if (req == 2'b11) begin
            grant_id = ~last_grant;
        end else if (req[1]) begin
            grant_id = 1'b1;
        end
    end

endmodule

// File: rtl/user_mux.sv
// Packet-granular merge of two AXI-Stream tenants into one registered master stream.
// Define USER_MUX_TAG_EN to stamp the source index into m_axis.tuser[39:32].
module user_mux
    import user_mux_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128
) (
    input  logic       axis_aclk,
    input  logic       axis_reset,
    user_mux_if.slave  s_axis_0,
    user_mux_if.slave  s_axis_1,
    user_mux_if.master m_axis,
    output logic [1:0] dbg_state
);

    if (C_S_AXIS_DATA_WIDTH != C_M_AXIS_DATA_WIDTH) begin : g_width_check
        $error("user_mux: slave and master data widths must match");
    end
    if (C_M_AXIS_TUSER_WIDTH < USER_ID_LSB + USER_ID_WIDTH) begin : g_tuser_check
        $error("user_mux: tuser must be at least 40 bits wide");
    end

    logic [1:0] state, state_nxt;
    logic       in_pkt;
    logic       grant_id;
    logic       out_ready, pass, sel;
    logic       sel_valid, sel_last, other_valid, hs, done;

    logic [C_M_AXIS_DATA_WIDTH-1:0]   sel_data;
    logic [C_M_AXIS_DATA_WIDTH/8-1:0] sel_keep;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]  sel_user;

    assign out_ready   = !m_axis.tvalid || m_axis.tready;
    assign pass        = (state == ST_PASS_0) || (state == ST_PASS_1);
    assign sel         = (state == ST_PASS_1);
    assign sel_valid   = sel ? s_axis_1.tvalid : s_axis_0.tvalid;
    assign sel_last    = sel ? s_axis_1.tlast  : s_axis_0.tlast;
    assign other_valid = sel ? s_axis_0.tvalid : s_axis_1.tvalid;
    assign hs          = pass && sel_valid && out_ready;
    assign done        = hs && sel_last;

    assign s_axis_0.tready = (state == ST_PASS_0) && out_ready;
    assign s_axis_1.tready = (state == ST_PASS_1) && out_ready;
    assign dbg_state       = state;

    rr_arbiter2 u_arb (
        .clk       (axis_aclk),
        .rst       (axis_reset),
        .req       ({s_axis_1.tvalid, s_axis_0.tvalid}),
        .update    (done),
        .update_id (sel),
        .grant_id  (grant_id)
    );

    // A granted port that goes quiet between packets releases the grant, so the
    // other tenant is never starved waiting for a packet that may not come.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (s_axis_0.tvalid || s_axis_1.tvalid) begin
                    state_nxt = pass_state(grant_id);
                end
            end
            ST_PASS_0, ST_PASS_1: begin
                if (done) begin
                    state_nxt = other_valid ? pass_state(~sel) : state;
                end else if (!in_pkt && !sel_valid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            state  <= ST_IDLE;
            in_pkt <= 1'b0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                in_pkt <= !sel_last;
            end
        end
    end

    always_comb begin
        sel_data = sel ? s_axis_1.tdata : s_axis_0.tdata;
        sel_keep = sel ? s_axis_1.tkeep : s_axis_0.tkeep;
        sel_user = sel ? s_axis_1.tuser : s_axis_0.tuser;
`ifdef USER_MUX_TAG_EN
        sel_user[USER_ID_LSB +: USER_ID_WIDTH] = {{(USER_ID_WIDTH-1){1'b0}}, sel};
`endif
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            m_axis.tkeep  <= '0;
            m_axis.tuser  <= '0;
            m_axis.tlast  <= 1'b0;
        end else if (hs) begin
            m_axis.tvalid <= 1'b1;
            m_axis.tdata  <= sel_data;
            m_axis.tkeep  <= sel_keep;
            m_axis.tuser  <= sel_user;
            m_axis.tlast  <= sel_last;
        end else if (m_axis.tready) begin
            m_axis.tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_user_mux.sv
// Bench for user_mux: per-port expected-beat queues, packet-order rules and a
// negedge monitor that scores every master beat.
module tb_user_mux;
    import user_mux_pkg::*;

    localparam int DW = 32;
    localparam int UW = 48;
    localparam int KW = DW / 8;
    localparam int BW = 1 + UW + KW + DW;

    // clock / reset
    logic axis_aclk  = 1'b0;
    logic axis_reset = 1'b0;
    always #5 axis_aclk = ~axis_aclk;

    user_mux_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) s0 ();
    user_mux_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) s1 ();
    user_mux_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) m ();
    logic [1:0] dbg_state;

    logic [DW-1:0] d_data  [2];
    logic [KW-1:0] d_keep  [2];
    logic [UW-1:0] d_user  [2];
    logic          d_valid [2];
    logic          d_last  [2];
    logic          m_ready;
    logic          abort;

    assign s0.tdata  = d_data[0];
    assign s0.tkeep  = d_keep[0];
    assign s0.tuser  = d_user[0];
    assign s0.tvalid = d_valid[0];
    assign s0.tlast  = d_last[0];
    assign s1.tdata  = d_data[1];
    assign s1.tkeep  = d_keep[1];
    assign s1.tuser  = d_user[1];
    assign s1.tvalid = d_valid[1];
    assign s1.tlast  = d_last[1];
    assign m.tready  = m_ready;

    user_mux #(
        .C_M_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_M_AXIS_TUSER_WIDTH (UW)
    ) dut (
        .axis_aclk  (axis_aclk),
        .axis_reset (axis_reset),
        .s_axis_0   (s0),
        .s_axis_1   (s1),
        .m_axis     (m),
        .dbg_state  (dbg_state)
    );

    // scoreboard
    int total = 0;
    int bad   = 0;
    logic [BW-1:0] exp_q0[$];
    logic [BW-1:0] exp_q1[$];
    int out_cyc_q[$];
    int pkt_src_q[$];

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] mkbeat(input logic last, input logic [UW-1:0] u,
                                             input logic [KW-1:0] k, input logic [DW-1:0] d);
        return {last, u, k, d};
    endfunction

    function automatic logic [UW-1:0] tag_user(input logic [UW-1:0] u, input int p);
        logic [UW-1:0] r;
        r = u;
`ifdef USER_MUX_TAG_EN
        r[39:32] = (p == 1) ? 8'h01 : 8'h00;
`else
        if (p > 1) r = '0;
`endif
        return r;
    endfunction

    function automatic logic rdy_of(input int p);
        return (p == 1) ? s1.tready : s0.tready;
    endfunction

    // driver tasks
    task automatic send_beat(input int p, input bit last, input bit force_ab);
        logic [31:0]   r;
        logic [63:0]   w;
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        int            n;
        if (abort) return;
        r = $urandom;
        d = {p[0], r[DW-2:0]};
        w = {$urandom, $urandom};
        u = w[UW-1:0];
        if (force_ab) u[39:32] = 8'hAB;
        d_data[p] = d;
        d_user[p] = u;
        d_keep[p] = w[63:60];
        d_last[p] = last;
        if (p == 1) exp_q1.push_back(mkbeat(last, tag_user(u, p), w[63:60], d));
        else        exp_q0.push_back(mkbeat(last, tag_user(u, p), w[63:60], d));
        d_valid[p] = 1'b1;
        n = 0;
        forever begin
            @(negedge axis_aclk);
            if (abort || rdy_of(p)) break;
            n++;
            if (n > 400) begin
                total++;
                bad++;
                $display("FAIL slave_timeout: port %0d waited %0d cycles, required < 400", p, n);
                break;
            end
        end
        if (!abort) begin
            @(posedge axis_aclk);
            #1;
        end
        d_valid[p] = 1'b0;
    endtask

    task automatic send_pkt(input int p, input int nb, input int maxgap, input bit force_ab);
        for (int i = 0; i < nb; i++) begin
            send_beat(p, i == nb - 1, force_ab);
            if (maxgap > 0 && i < nb - 1) begin
                repeat ($urandom_range(0, maxgap)) begin
                    @(posedge axis_aclk);
                    #1;
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, BW'(m.tvalid), '0);
        check({tag, "_tdata"},  BW'(m.tdata), '0);
        check({tag, "_tuser"},  BW'(m.tuser), '0);
        check({tag, "_tkeep_tlast"}, BW'({m.tkeep, m.tlast}), '0);
        check({tag, "_s_tready"}, BW'({s0.tready, s1.tready}), '0);
        check({tag, "_state"}, BW'(dbg_state), BW'(ST_IDLE));
    endtask

    task automatic do_reset();
        @(posedge axis_aclk);
        #1;
        axis_reset = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge axis_aclk);
        #1;
        axis_reset = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        m_ready = 1'b1;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || m.tvalid) && n < 500) begin
            @(posedge axis_aclk);
            #1;
            n++;
        end
        total++;
        if (n >= 500) begin
            bad++;
            $display("FAIL drain: %0d/%0d beats still expected, required 0/0", exp_q0.size(), exp_q1.size());
        end
    endtask

    task automatic clear_logs();
        out_cyc_q.delete();
        pkt_src_q.delete();
    endtask

    // monitor: master scoreboard, 1-cycle latency, stall stability, packet order
    int            cyc = 0;
    logic          lat_pend = 1'b0, hold_pend = 1'b0;
    logic [BW-1:0] lat_beat, hold_beat;
    logic          out_open = 1'b0, out_src = 1'b0;
    logic          s_open = 1'b0, s_src = 1'b0;
    logic          fair_pend = 1'b0, fair_src = 1'b0;

    always @(negedge axis_aclk) begin
        logic [BW-1:0] mb, eb;
        logic          src;
        logic [1:0]    rdy;
        cyc++;
        if (axis_reset) begin
            lat_pend  = 1'b0;
            hold_pend = 1'b0;
            out_open  = 1'b0;
            s_open    = 1'b0;
            fair_pend = 1'b0;
        end else begin
            mb = mkbeat(m.tlast, m.tuser, m.tkeep, m.tdata);
            if (lat_pend) begin
                check("latency_valid", BW'(m.tvalid), BW'(1));
                check("latency_beat", mb, lat_beat);
            end
            if (hold_pend) begin
                check("hold_valid", BW'(m.tvalid), BW'(1));
                check("hold_beat", mb, hold_beat);
            end
            if (m.tvalid && !m.tready) begin
                check("stall_s_tready", BW'({s0.tready, s1.tready}), '0);
                hold_pend = 1'b1;
                hold_beat = mb;
            end else begin
                hold_pend = 1'b0;
            end
            if (m.tvalid && m.tready) begin
                src = m.tdata[DW-1];
                if (out_open) check("out_no_interleave", BW'(src), BW'(out_src));
                else          pkt_src_q.push_back(int'(src));
                out_cyc_q.push_back(cyc);
                if ((src ? exp_q1.size() : exp_q0.size()) == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %h from port %0d, required none", mb, src);
                end else begin
                    eb = src ? exp_q1.pop_front() : exp_q0.pop_front();
                    check(src ? "beat_p1" : "beat_p0", mb, eb);
                end
                out_open = !m.tlast;
                out_src  = src;
            end
            lat_pend = 1'b0;
            rdy = {s1.tready, s0.tready};
            if (d_valid[0] && rdy[0] && d_valid[1] && rdy[1]) begin
                total++;
                bad++;
                $display("FAIL double_grant: both slave ports accepted, required one");
            end
            for (int p = 0; p < 2; p++) begin
                if (d_valid[p] && rdy[p]) begin
                    lat_pend = 1'b1;
                    lat_beat = mkbeat(d_last[p], tag_user(d_user[p], p), d_keep[p], d_data[p]);
                    if (!s_open && fair_pend) begin
                        check("alternation", BW'(p), BW'(fair_src));
                        fair_pend = 1'b0;
                    end
                    if (s_open) check("slave_no_interleave", BW'(p), BW'(s_src));
                    s_open = !d_last[p];
                    s_src  = p[0];
                    if (d_last[p] && d_valid[1-p]) begin
                        fair_pend = 1'b1;
                        fair_src  = ~p[0];
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // stimulus
    logic [3:0] pat;
    bit         rand_done;
    initial begin
        for (int p = 0; p < 2; p++) begin
            d_data[p] = '0; d_keep[p] = '0; d_user[p] = '0;
            d_valid[p] = 1'b0; d_last[p] = 1'b0;
        end
        m_ready = 1'b1;
        abort   = 1'b0;
        #2 axis_reset = 1'b1;
        #1 check_reset_outputs("por");
        repeat (2) @(posedge axis_aclk);
        #1 axis_reset = 1'b0;

        // single 3-beat packet on port 0, port 1 never granted
        clear_logs();
        fork
            send_pkt(0, 3, 0, 0);
            begin
                repeat (8) begin
                    @(negedge axis_aclk);
                    check("s1_tready_idle", BW'(s1.tready), '0);
                end
            end
        join
        wait_drain();
        check("t1_beats", BW'(out_cyc_q.size()), BW'(3));
        if (out_cyc_q.size() == 3) check("t1_contig", BW'(out_cyc_q[2] - out_cyc_q[0]), BW'(2));

        // simultaneous 2-beat packets after reset: port 0 first, no bubble
        do_reset();
        clear_logs();
        fork
            send_pkt(0, 2, 0, 0);
            send_pkt(1, 2, 0, 0);
        join
        wait_drain();
        check("t2_pkts", BW'(pkt_src_q.size()), BW'(2));
        if (pkt_src_q.size() == 2) begin
            check("t2_first", BW'(pkt_src_q[0]), BW'(0));
            check("t2_second", BW'(pkt_src_q[1]), BW'(1));
        end
        if (out_cyc_q.size() == 4) check("t2_contig", BW'(out_cyc_q[3] - out_cyc_q[0]), BW'(3));
        else check("t2_beats", BW'(out_cyc_q.size()), BW'(4));

        // downstream stalls 1,0,0,1 during a port 1 packet
        clear_logs();
        pat = 4'b1001;
        fork
            send_pkt(1, 4, 0, 0);
            begin
                for (int i = 0; i < 12; i++) begin
                    m_ready = pat[i % 4];
                    @(posedge axis_aclk);
                    #1;
                end
                m_ready = 1'b1;
            end
        join
        wait_drain();
        check("t3_beats", BW'(out_cyc_q.size()), BW'(4));

        // port 0 streams back-to-back while port 1 waits: strict alternation
        clear_logs();
        fork
            repeat (3) send_pkt(0, 2, 0, 0);
            send_pkt(1, 2, 0, 0);
        join
        wait_drain();
        check("t4_pkts", BW'(pkt_src_q.size()), BW'(4));
        if (pkt_src_q.size() == 4) begin
            check("t4_order", BW'({pkt_src_q[0][0], pkt_src_q[1][0], pkt_src_q[2][0], pkt_src_q[3][0]}),
                  BW'(4'b0100));
        end

        // reset during beat 2 of a 4-beat packet; next tie goes to port 0
        clear_logs();
        fork
            send_pkt(0, 4, 0, 0);
            begin
                for (int n = 0; n < 50 && out_cyc_q.size() == 0; n++) @(negedge axis_aclk);
                check("t5_first_beat", BW'(out_cyc_q.size()), BW'(1));
                @(posedge axis_aclk);
                #1;
                axis_reset = 1'b1;
                abort      = 1'b1;
                #1 check_reset_outputs("midpkt");
            end
        join
        d_valid[0] = 1'b0;
        d_valid[1] = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        repeat (2) @(posedge axis_aclk);
        #1;
        abort      = 1'b0;
        axis_reset = 1'b0;
        clear_logs();
        fork
            send_pkt(0, 1, 0, 0);
            send_pkt(1, 1, 0, 0);
        join
        wait_drain();
        check("t5_pkts", BW'(pkt_src_q.size()), BW'(2));
        if (pkt_src_q.size() == 2) check("t5_first", BW'(pkt_src_q[0]), BW'(0));

        // tuser[39:32]=AB on port 1
        clear_logs();
        send_pkt(1, 2, 0, 1);
        wait_drain();
        check("t6_beats", BW'(out_cyc_q.size()), BW'(2));

        // randomized traffic with downstream backpressure
        rand_done = 1'b0;
        fork
            begin
                fork
                    for (int k = 0; k < 25; k++) begin
                        send_pkt(0, $urandom_range(1, 5), 2, 0);
                        repeat ($urandom_range(0, 3)) begin @(posedge axis_aclk); #1; end
                    end
                    for (int k = 0; k < 25; k++) begin
                        send_pkt(1, $urandom_range(1, 5), 2, $urandom_range(0, 1) == 1);
                        repeat ($urandom_range(0, 3)) begin @(posedge axis_aclk); #1; end
                    end
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    m_ready = ($urandom_range(0, 3) != 0);
                    @(posedge axis_aclk);
                    #1;
                end
            end
        join
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
